sc_max7219_tx: RTL and testbench



---
 rtl/sc_max7219_tx.sv | 174 +++++++++++++++++
 tb/tb_sc_max7219_tx.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_max7219_tx.sv
// sc_max7219_tx: shifts the eight LED-matrix row registers into a MAX7219 as
// eight 16-bit words (MSB first), one frame per start request.
// Optional build macro SC_MAX7219TX_INIT_EN: after reset, send the five
// driver configuration words before accepting frames.
module sc_max7219_tx #(
    parameter int unsigned CLKDIV    = 4,
    parameter logic [3:0]  INTENSITY = 4'h8
) (
    input  logic       SC_MAX7219TX_CLOCK_50,
    input  logic       SC_MAX7219TX_RESET_InHigh,
    input  logic       SC_MAX7219TX_Start_InHigh,
    input  logic [7:0] SC_MAX7219TX_Row0,
    input  logic [7:0] SC_MAX7219TX_Row1,
    input  logic [7:0] SC_MAX7219TX_Row2,
    input  logic [7:0] SC_MAX7219TX_Row3,
    input  logic [7:0] SC_MAX7219TX_Row4,
    input  logic [7:0] SC_MAX7219TX_Row5,
    input  logic [7:0] SC_MAX7219TX_Row6,
    input  logic [7:0] SC_MAX7219TX_Row7,
    output logic       SC_MAX7219TX_Din,
    output logic       SC_MAX7219TX_Sclk,
    output logic       SC_MAX7219TX_Load,
    output logic       SC_MAX7219TX_Busy,
    output logic       SC_MAX7219TX_FrameDone
);

    localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

`ifdef SC_MAX7219TX_INIT_EN
    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_FRAME} state_t;
    localparam state_t ST_RESET = ST_INIT;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_FRAME} state_t;
    localparam state_t ST_RESET = ST_IDLE;
`endif

    // HOLD: no word on the wire (after reset, or idle between frames)
    typedef enum logic [1:0] {PH_HOLD, PH_SHIFT, PH_GAP} phase_t;

    state_t     state, state_nx;
    phase_t     phase, phase_nx;
    logic [7:0] div_cnt, div_nx;
    logic [3:0] bit_cnt, bit_nx;
    logic [2:0] word_idx, word_nx;
    logic       sclk_r, sclk_nx;
    logic       done_r, done_nx;
    logic       take;
    logic [2:0] last_idx;
    logic [15:0] word;
    logic [7:0] snap [8];

`ifndef SC_MAX7219TX_INIT_EN
    logic [3:0] unused_intensity;
    assign unused_intensity = INTENSITY;
`endif

    // Select the word currently on the wire: config ROM during init, else address+snapshot row
    always_comb begin
        word     = {{5'd0, word_idx} + 8'd1, snap[word_idx]};
        last_idx = 3'd7;
`ifdef SC_MAX7219TX_INIT_EN
        if (state == ST_INIT) begin
            last_idx = 3'd4;
            case (word_idx)
                3'd0:    word = 16'h0F00;
                3'd1:    word = 16'h0900;
                3'd2:    word = {12'h0A0, INTENSITY};
                3'd3:    word = 16'h0B07;
                default: word = 16'h0C01;
            endcase
        end
`endif
    end

    // Next-state logic for the frame FSM and the bit/word engine
    always_comb begin
        state_nx = state;
        phase_nx = phase;
        div_nx   = div_cnt;
        bit_nx   = bit_cnt;
        word_nx  = word_idx;
        sclk_nx  = sclk_r;
        done_nx  = 1'b0;
        take     = 1'b0;
        case (phase)
            PH_HOLD: begin
                if (state == ST_IDLE) begin
                    if (SC_MAX7219TX_Start_InHigh) begin
                        take     = 1'b1;
                        state_nx = ST_FRAME;
                        phase_nx = PH_SHIFT;
                    end
                end else begin
                    phase_nx = PH_SHIFT;
                end
            end
            PH_SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_nx  = '0;
                    sclk_nx = ~sclk_r;
                    if (sclk_r) begin
                        if (bit_cnt == 4'd15) begin
                            bit_nx   = '0;
                            phase_nx = PH_GAP;
                        end else begin
                            bit_nx = bit_cnt + 4'd1;
                        end
                    end
                end else begin
                    div_nx = div_cnt + 8'd1;
                end
            end
            PH_GAP: begin
                if (div_cnt == DIV_LAST) begin
                    div_nx = '0;
                    if (word_idx == last_idx) begin
                        word_nx  = '0;
                        phase_nx = PH_HOLD;
                        state_nx = ST_IDLE;
                        done_nx  = (state == ST_FRAME);
                    end else begin
                        word_nx  = word_idx + 3'd1;
                        phase_nx = PH_SHIFT;
                    end
                end else begin
                    div_nx = div_cnt + 8'd1;
                end
            end
            default: phase_nx = PH_HOLD;
        endcase
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge SC_MAX7219TX_CLOCK_50) begin
        if (SC_MAX7219TX_RESET_InHigh) begin
            state    <= ST_RESET;
            phase    <= PH_HOLD;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            word_idx <= '0;
            sclk_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state    <= state_nx;
            phase    <= phase_nx;
            div_cnt  <= div_nx;
            bit_cnt  <= bit_nx;
            word_idx <= word_nx;
            sclk_r   <= sclk_nx;
            done_r   <= done_nx;
        end
    end

    // Snapshot all rows on the edge a start request is accepted
    always_ff @(posedge SC_MAX7219TX_CLOCK_50) begin
        if (take && !SC_MAX7219TX_RESET_InHigh) begin
            snap[0] <= SC_MAX7219TX_Row0;
            snap[1] <= SC_MAX7219TX_Row1;
            snap[2] <= SC_MAX7219TX_Row2;
            snap[3] <= SC_MAX7219TX_Row3;
            snap[4] <= SC_MAX7219TX_Row4;
            snap[5] <= SC_MAX7219TX_Row5;
            snap[6] <= SC_MAX7219TX_Row6;
            snap[7] <= SC_MAX7219TX_Row7;
        end
    end

    assign SC_MAX7219TX_Load      = (phase != PH_SHIFT);
    assign SC_MAX7219TX_Sclk      = (phase == PH_SHIFT) && sclk_r;
    assign SC_MAX7219TX_Din       = (phase == PH_SHIFT) && word[4'd15 - bit_cnt];
    assign SC_MAX7219TX_Busy      = (state != ST_IDLE);
    assign SC_MAX7219TX_FrameDone = done_r;

endmodule

// File: tb/tb_sc_max7219_tx.sv
// Self-checking bench for sc_max7219_tx; decodes the serial stream back
// into words and compares against frames computed from the row values.
module tb_sc_max7219_tx;

    localparam int unsigned CLKDIV = 2;
    localparam logic [3:0]  INTENS = 4'h8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] row [8];
    logic       din, sclk, load, busy, fd;

    int asserts = 0;
    int errors  = 0;
    int cyc     = 0;

    logic [15:0] words[$];
    int          load_low_t[$];
    int          fd_t[$];
    int          stab_err = 0;
    int          nbits = 0;
    logic [15:0] sh = '0;
    logic        p_sclk = 1'b0, p_load = 1'b1, p_din = 1'b0;

    sc_max7219_tx #(.CLKDIV(CLKDIV), .INTENSITY(INTENS)) dut (
        .SC_MAX7219TX_CLOCK_50    (clk),
        .SC_MAX7219TX_RESET_InHigh(rst),
        .SC_MAX7219TX_Start_InHigh(start),
        .SC_MAX7219TX_Row0        (row[0]),
        .SC_MAX7219TX_Row1        (row[1]),
        .SC_MAX7219TX_Row2        (row[2]),
        .SC_MAX7219TX_Row3        (row[3]),
        .SC_MAX7219TX_Row4        (row[4]),
        .SC_MAX7219TX_Row5        (row[5]),
        .SC_MAX7219TX_Row6        (row[6]),
        .SC_MAX7219TX_Row7        (row[7]),
        .SC_MAX7219TX_Din         (din),
        .SC_MAX7219TX_Sclk        (sclk),
        .SC_MAX7219TX_Load        (load),
        .SC_MAX7219TX_Busy        (busy),
        .SC_MAX7219TX_FrameDone   (fd)
    );

    always #5 clk = ~clk;

    // Cycle counter used for timestamps
    always @(posedge clk) cyc++;

    // Serial decoder: shift Din on Sclk rise, emit a word on Load rise
    always @(negedge clk) begin
        if (load === 1'b0 && p_load === 1'b1) load_low_t.push_back(cyc);
        if (load === 1'b0 && sclk === 1'b1 && p_sclk === 1'b0) begin
            sh = {sh[14:0], din};
            nbits++;
        end
        if (sclk === 1'b1 && p_sclk === 1'b1 && din !== p_din) stab_err++;
        if (load === 1'b1 && sclk !== 1'b0) stab_err++;
        if (load === 1'b1 && p_load === 1'b0) begin
            if (nbits == 16) words.push_back(sh);
            nbits = 0;
        end
        if (fd === 1'b1) fd_t.push_back(cyc);
        p_sclk = sclk;
        p_load = load;
        p_din  = din;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        words.delete();
        load_low_t.delete();
        fd_t.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_fd(input int budget, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < budget) begin
            samp();
            if (fd === 1'b1) ok = 1'b1;
            n++;
        end
    endtask

    task automatic test_reset();
        logic exp_busy;
`ifdef SC_MAX7219TX_INIT_EN
        exp_busy = 1'b1;
`else
        exp_busy = 1'b0;
`endif
        for (int k = 0; k < 8; k++) row[k] = 8'h00;
        rst = 1'b1;
        repeat (3) tick();
        samp();
        asserts++; if (load !== 1'b1) begin errors++; $display("FAIL reset_load: got %b expected 1", load); end
        asserts++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
        asserts++; if (din !== 1'b0) begin errors++; $display("FAIL reset_din: got %b expected 0", din); end
        asserts++; if (fd !== 1'b0) begin errors++; $display("FAIL reset_framedone: got %b expected 0", fd); end
        asserts++; if (busy !== exp_busy) begin errors++; $display("FAIL reset_busy: got %b expected %b", busy, exp_busy); end
        clear_mon();
        rst = 1'b0;
        samp();
        asserts++; if (busy !== exp_busy) begin errors++; $display("FAIL busy_after_release: got %b expected %b", busy, exp_busy); end
    endtask

`ifdef SC_MAX7219TX_INIT_EN
    task automatic test_init();
        logic [15:0] exp [5];
        int n = 0;
        exp[0] = 16'h0F00; exp[1] = 16'h0900; exp[2] = {12'h0A0, INTENS};
        exp[3] = 16'h0B07; exp[4] = 16'h0C01;
        while (busy !== 1'b0 && n < 400 * CLKDIV) begin samp(); n++; end
        asserts++; if (busy !== 1'b0) begin errors++; $display("FAIL init_timeout: busy=%b expected 0", busy); end
        asserts++;
        if (load_low_t.size() == 0) begin errors++; $display("FAIL init_busy_time: no Load low seen"); end
        else if (cyc - load_low_t[0] != 165 * CLKDIV) begin
            errors++; $display("FAIL init_busy_time: got %0d expected %0d", cyc - load_low_t[0], 165 * CLKDIV);
        end
        asserts++; if (words.size() != 5) begin errors++; $display("FAIL init_word_count: got %0d expected 5", words.size()); end
        for (int k = 0; k < 5 && k < words.size(); k++) begin
            asserts++;
            if (words[k] !== exp[k]) begin errors++; $display("FAIL init_word%0d: got %h expected %h", k, words[k], exp[k]); end
        end
    endtask
`else
    task automatic test_no_activity();
        repeat (200) samp();
        asserts++; if (load_low_t.size() != 0) begin errors++; $display("FAIL idle_activity: got %0d words expected 0", load_low_t.size()); end
        asserts++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask
`endif

    task automatic test_frame_basic();
        logic [7:0] pat [8];
        logic [15:0] exp;
        bit ok;
        pat = '{8'h00, 8'h42, 8'h3C, 8'h00, 8'h24, 8'h24, 8'h24, 8'h00};
        for (int k = 0; k < 8; k++) row[k] = pat[k];
        samp();
        clear_mon();
        pulse_start();
        samp();
        asserts++; if (load !== 1'b0) begin errors++; $display("FAIL start_latency: load=%b expected 0", load); end
        wait_fd(700, ok);
        asserts++; if (!ok) begin errors++; $display("FAIL frame_timeout: framedone=%b expected 1", fd); end
        asserts++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %b expected 0", busy); end
        asserts++; if (words.size() != 8) begin errors++; $display("FAIL frame_word_count: got %0d expected 8", words.size()); end
        for (int k = 0; k < 8 && k < words.size(); k++) begin
            exp = {8'(k + 1), pat[k]};
            asserts++;
            if (words[k] !== exp) begin errors++; $display("FAIL frame_word%0d: got %h expected %h", k, words[k], exp); end
        end
        asserts++;
        if (fd_t.size() == 0 || load_low_t.size() == 0) begin errors++; $display("FAIL frame_time: missing events"); end
        else if (fd_t[0] - load_low_t[0] != 264 * CLKDIV) begin
            errors++; $display("FAIL frame_time: got %0d expected %0d", fd_t[0] - load_low_t[0], 264 * CLKDIV);
        end
        samp();
        asserts++; if (fd !== 1'b0) begin errors++; $display("FAIL framedone_pulse: got %b expected 0", fd); end
    endtask

    task automatic test_random_frames();
        logic [7:0] pat [8];
        logic [15:0] exp;
        bit ok;
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 8; k++) begin pat[k] = 8'($urandom); row[k] = pat[k]; end
            clear_mon();
            pulse_start();
            wait_fd(700, ok);
            asserts++; if (!ok) begin errors++; $display("FAIL rand_timeout%0d: framedone=%b expected 1", f, fd); end
            asserts++; if (words.size() != 8) begin errors++; $display("FAIL rand_count%0d: got %0d expected 8", f, words.size()); end
            for (int k = 0; k < 8 && k < words.size(); k++) begin
                exp = {8'(k + 1), pat[k]};
                asserts++;
                if (words[k] !== exp) begin errors++; $display("FAIL rand%0d_word%0d: got %h expected %h", f, k, words[k], exp); end
            end
        end
    endtask

    task automatic test_row_change();
        logic [7:0] pat [8];
        logic [15:0] exp;
        bit ok;
        int n = 0;
        for (int k = 0; k < 8; k++) begin pat[k] = 8'($urandom_range(0, 254)); row[k] = pat[k]; end
        samp();
        clear_mon();
        pulse_start();
        while (words.size() < 3 && n < 400) begin samp(); n++; end
        for (int k = 0; k < 8; k++) row[k] = 8'hFF;
        wait_fd(700, ok);
        asserts++; if (!ok) begin errors++; $display("FAIL chg_timeout: framedone=%b expected 1", fd); end
        for (int k = 0; k < 8 && k < words.size(); k++) begin
            exp = {8'(k + 1), pat[k]};
            asserts++;
            if (words[k] !== exp) begin errors++; $display("FAIL chg_word%0d: got %h expected %h", k, words[k], exp); end
        end
        clear_mon();
        pulse_start();
        wait_fd(700, ok);
        asserts++; if (words.size() != 8) begin errors++; $display("FAIL chg_next_count: got %0d expected 8", words.size()); end
        for (int k = 0; k < 8 && k < words.size(); k++) begin
            exp = {8'(k + 1), 8'hFF};
            asserts++;
            if (words[k] !== exp) begin errors++; $display("FAIL chg_next_word%0d: got %h expected %h", k, words[k], exp); end
        end
    endtask

    task automatic test_busy_ignore();
        bit ok;
        for (int k = 0; k < 8; k++) row[k] = 8'($urandom);
        samp();
        clear_mon();
        pulse_start();
        repeat (100) samp();
        asserts++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid_frame: got %b expected 1", busy); end
        pulse_start();
        wait_fd(700, ok);
        repeat (40 * CLKDIV) samp();
        asserts++; if (load_low_t.size() != 8) begin errors++; $display("FAIL ignored_start: got %0d words expected 8", load_low_t.size()); end
        asserts++; if (busy !== 1'b0) begin errors++; $display("FAIL ignored_busy: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat [8];
        logic [15:0] exp;
        bit ok;
        for (int k = 0; k < 8; k++) begin pat[k] = 8'($urandom); row[k] = pat[k]; end
        samp();
        clear_mon();
        start = 1'b1;
        wait_fd(700, ok);
        samp();
        asserts++; if (load !== 1'b0) begin errors++; $display("FAIL b2b_restart: load=%b expected 0", load); end
        start = 1'b0;
        asserts++;
        if (load_low_t.size() < 9 || fd_t.size() == 0) begin errors++; $display("FAIL b2b_gap: got %0d words expected 9", load_low_t.size()); end
        else if (load_low_t[8] != fd_t[0] + 1) begin
            errors++; $display("FAIL b2b_gap: got %0d expected %0d", load_low_t[8], fd_t[0] + 1);
        end
        wait_fd(700, ok);
        asserts++; if (words.size() != 16) begin errors++; $display("FAIL b2b_count: got %0d expected 16", words.size()); end
        for (int k = 0; k < 16 && k < words.size(); k++) begin
            exp = {8'((k % 8) + 1), pat[k % 8]};
            asserts++;
            if (words[k] !== exp) begin errors++; $display("FAIL b2b_word%0d: got %h expected %h", k, words[k], exp); end
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        for (int k = 0; k < 8; k++) row[k] = 8'($urandom);
        samp();
        clear_mon();
        pulse_start();
        while (load_low_t.size() < 3 && n < 400) begin samp(); n++; end
        repeat (14 * CLKDIV + 1) samp();
        rst = 1'b1;
        samp();
        asserts++; if (load !== 1'b1) begin errors++; $display("FAIL midrst_load: got %b expected 1", load); end
        asserts++; if (sclk !== 1'b0) begin errors++; $display("FAIL midrst_sclk: got %b expected 0", sclk); end
        asserts++; if (din !== 1'b0) begin errors++; $display("FAIL midrst_din: got %b expected 0", din); end
        asserts++; if (fd !== 1'b0) begin errors++; $display("FAIL midrst_framedone: got %b expected 0", fd); end
        asserts++; if (words.size() != 2) begin errors++; $display("FAIL midrst_words: got %0d expected 2", words.size()); end
        clear_mon();
        rst = 1'b0;
        samp();
`ifdef SC_MAX7219TX_INIT_EN
        n = 0;
        while (busy !== 1'b0 && n < 400 * CLKDIV) begin samp(); n++; end
        asserts++; if (words.size() != 5) begin errors++; $display("FAIL midrst_init_count: got %0d expected 5", words.size()); end
        asserts++;
        if (words.size() == 0) begin errors++; $display("FAIL midrst_init_first: no word seen"); end
        else if (words[0] !== 16'h0F00) begin errors++; $display("FAIL midrst_init_first: got %h expected 0f00", words[0]); end
`else
        repeat (100) samp();
        asserts++; if (load_low_t.size() != 0) begin errors++; $display("FAIL midrst_activity: got %0d expected 0", load_low_t.size()); end
        asserts++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
`endif
    endtask

    task automatic test_din_stable();
        asserts++; if (stab_err != 0) begin errors++; $display("FAIL din_stable: got %0d violations expected 0", stab_err); end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) row[k] = 8'h00;
        test_reset();
`ifdef SC_MAX7219TX_INIT_EN
        test_init();
`else
        test_no_activity();
`endif
        test_frame_basic();
        test_random_frames();
        test_row_change();
        test_busy_ignore();
        test_back_to_back();
        test_mid_reset();
        test_din_stable();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
        $finish;
    end

endmodule
